floor_request_unit: RTL and testbench

- Producer side of the floor-call interface into the elevator FSM.
- Conditions the three raw floor buttons with a synchroniser and debouncer, and latches each press as a pending call.
- Arbitrates pending calls and drives one one-hot floor request onto the FSM's g_f/f_f/s_f inputs.
- Holds the request until the FSM's current floor reaches the target, then retires the call.

---
 rtl/floor_pkg.sv | 29 ++
 rtl/btn_debounce.sv | 42 ++++
 rtl/floor_request_unit.sv | 146 ++++++++++++++
 tb/tb_floor_request_unit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/floor_pkg.sv
// rtl/floor_pkg.sv - shared floor encodings, FSM state and direction types
package floor_pkg;

    localparam logic [1:0] FLOOR_G = 2'd0;
    localparam logic [1:0] FLOOR_F = 2'd1;
    localparam logic [1:0] FLOOR_S = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    // Illegal encoding 3 maps to no floor so it can never match a pending bit.
    function automatic logic [2:0] floor_onehot(input logic [1:0] f);
        case (f)
            FLOOR_G: floor_onehot = 3'b001;
            FLOOR_F: floor_onehot = 3'b010;
            FLOOR_S: floor_onehot = 3'b100;
            default: floor_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, saturating debounce counter, press edge detect
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    // Gating with sync2 drops the level on the very first low sample.
    assign level = sync2 && (cnt == CNT_MAX);
    assign press = level & ~level_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            if (!sync2) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/floor_request_unit.sv
// rtl/floor_request_unit.sv - floor call latch, nearest-floor arbitration and request FSM
module floor_request_unit
    import floor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20,
    parameter int REISSUE_TICKS   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] btn_raw,
    input  logic       tick,
    input  logic [1:0] c_f,
    output logic [2:0] req_onehot,
    output logic [2:0] pending,
    output logic       busy
);

    localparam int RW = $clog2(REISSUE_TICKS + 1);
    localparam logic [RW-1:0] REISSUE_LAST = RW'(REISSUE_TICKS);

    logic [2:0]    press;
    state_t        state, state_n;
    dir_t          dir, dir_n;
    logic [1:0]    target, target_n;
    logic [1:0]    origin, origin_n;
    logic [RW-1:0] reissue_cnt, reissue_cnt_n;
    logic [2:0]    req_n;
    logic [2:0]    clr;
    logic [1:0]    cf_eff;
    logic [2:0]    own;
    logic [2:0]    cand;
    logic [1:0]    pick;
    logic          pick_valid;

    for (genvar i = 0; i < 3; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .raw  (btn_raw[i]),
            .press(press[i])
        );
    end

    assign cf_eff     = (c_f == 2'd3) ? FLOOR_G : c_f;
    assign own        = floor_onehot(c_f);
    assign cand       = pending & ~own;
    assign pick_valid = |cand;

    // Nearest pending floor; the only possible tie (at F with G and S) follows dir.
    always_comb begin
        pick = FLOOR_G;
        case (cf_eff)
            FLOOR_F: begin
                if (cand[1])                pick = FLOOR_F;
                else if (cand[0] && cand[2]) pick = (dir == UP) ? FLOOR_S : FLOOR_G;
                else if (cand[2])           pick = FLOOR_S;
                else                        pick = FLOOR_G;
            end
            FLOOR_S: begin
                if (cand[2])      pick = FLOOR_S;
                else if (cand[1]) pick = FLOOR_F;
                else              pick = FLOOR_G;
            end
            default: begin
                if (cand[0])      pick = FLOOR_G;
                else if (cand[1]) pick = FLOOR_F;
                else              pick = FLOOR_S;
            end
        endcase
    end

    always_comb begin
        state_n       = state;
        dir_n         = dir;
        target_n      = target;
        origin_n      = origin;
        reissue_cnt_n = reissue_cnt;
        req_n         = req_onehot;
        clr           = 3'b000;
        case (state)
            IDLE: begin
                clr   = pending & own;
                req_n = 3'b000;
                if (pick_valid) begin
                    state_n  = ISSUE;
                    target_n = pick;
                    origin_n = cf_eff;
                    req_n    = floor_onehot(pick);
                end
            end
            ISSUE: begin
                req_n = floor_onehot(target);
                if (tick) begin
                    state_n       = WAIT;
                    reissue_cnt_n = '0;
                end
            end
            WAIT: begin
                if (c_f == target) begin
                    clr     = floor_onehot(target);
                    dir_n   = (target > origin) ? UP : DOWN;
                    req_n   = 3'b000;
                    state_n = IDLE;
                end else if (tick) begin
                    if (reissue_cnt + 1'b1 == REISSUE_LAST) begin
                        state_n       = ISSUE;
                        reissue_cnt_n = '0;
                    end else begin
                        reissue_cnt_n = reissue_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            dir         <= UP;
            target      <= FLOOR_G;
            origin      <= FLOOR_G;
            reissue_cnt <= '0;
            pending     <= 3'b000;
            req_onehot  <= 3'b000;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            dir         <= dir_n;
            target      <= target_n;
            origin      <= origin_n;
            reissue_cnt <= reissue_cnt_n;
            pending     <= (pending | press) & ~clr;
            req_onehot  <= req_n;
            busy        <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_floor_request_unit.sv
// tb/tb_floor_request_unit.sv - directed table-driven bench for floor_request_unit
module tb_floor_request_unit;

    logic       clk;
    logic       reset;
    logic [2:0] btn_raw;
    logic       tick;
    logic [1:0] c_f;
    logic [2:0] req_onehot;
    logic [2:0] pending;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] btn;
        logic       tk;
        logic [1:0] cf;
        int         cycles;
        logic [2:0] pend;
        logic [2:0] req;
        logic       bsy;
    } vec_t;

    vec_t vecs [21];

    floor_request_unit #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (20),
        .REISSUE_TICKS  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .tick      (tick),
        .c_f       (c_f),
        .req_onehot(req_onehot),
        .pending   (pending),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] p, input logic [2:0] r, input logic b);
        check({tag, ".pending"}, pending, p);
        check({tag, ".req"}, req_onehot, r);
        check({tag, ".busy"}, {2'b00, busy}, {2'b00, b});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // press S, reissue, arrive at S
        vecs[0]  = '{3'b100, 1'b0, 2'd0, 6, 3'b000, 3'b000, 1'b0};
        vecs[1]  = '{3'b100, 1'b0, 2'd0, 1, 3'b100, 3'b000, 1'b0};
        vecs[2]  = '{3'b100, 1'b0, 2'd0, 1, 3'b100, 3'b100, 1'b1};
        vecs[3]  = '{3'b100, 1'b0, 2'd0, 2, 3'b100, 3'b100, 1'b1};
        vecs[4]  = '{3'b000, 1'b0, 2'd0, 3, 3'b100, 3'b100, 1'b1};
        vecs[5]  = '{3'b000, 1'b1, 2'd0, 1, 3'b100, 3'b100, 1'b1};
        vecs[6]  = '{3'b000, 1'b0, 2'd0, 1, 3'b100, 3'b100, 1'b1};
        vecs[7]  = '{3'b000, 1'b1, 2'd0, 2, 3'b100, 3'b100, 1'b1};
        vecs[8]  = '{3'b000, 1'b1, 2'd0, 1, 3'b100, 3'b100, 1'b1};
        vecs[9]  = '{3'b000, 1'b0, 2'd2, 1, 3'b000, 3'b000, 1'b0};
        // tie at F with dir UP: S first, then G
        vecs[10] = '{3'b101, 1'b0, 2'd1, 6, 3'b000, 3'b000, 1'b0};
        vecs[11] = '{3'b101, 1'b0, 2'd1, 1, 3'b101, 3'b000, 1'b0};
        vecs[12] = '{3'b101, 1'b0, 2'd1, 1, 3'b101, 3'b100, 1'b1};
        vecs[13] = '{3'b000, 1'b1, 2'd1, 1, 3'b101, 3'b100, 1'b1};
        vecs[14] = '{3'b000, 1'b0, 2'd2, 1, 3'b001, 3'b000, 1'b0};
        vecs[15] = '{3'b000, 1'b0, 2'd2, 1, 3'b001, 3'b001, 1'b1};
        vecs[16] = '{3'b000, 1'b1, 2'd2, 1, 3'b001, 3'b001, 1'b1};
        vecs[17] = '{3'b000, 1'b0, 2'd0, 1, 3'b000, 3'b000, 1'b0};
        // own-floor press in IDLE
        vecs[18] = '{3'b001, 1'b0, 2'd0, 7, 3'b001, 3'b000, 1'b0};
        vecs[19] = '{3'b001, 1'b0, 2'd0, 1, 3'b000, 3'b000, 1'b0};
        vecs[20] = '{3'b000, 1'b0, 2'd0, 3, 3'b000, 3'b000, 1'b0};

        reset   = 1'b0;
        btn_raw = 3'b000;
        tick    = 1'b0;
        c_f     = 2'd0;
        step(3);
        check_all("reset", 3'b000, 3'b000, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 21; i++) begin
            btn_raw = vecs[i].btn;
            tick    = vecs[i].tk;
            c_f     = vecs[i].cf;
            step(vecs[i].cycles);
            check_all($sformatf("vec%0d", i), vecs[i].pend, vecs[i].req, vecs[i].bsy);
        end
        tick = 1'b0;

        // bouncy F button never yields a press
        c_f = 2'd0;
        for (int k = 0; k < 5; k++) begin
            btn_raw = 3'b010;
            step(2);
            btn_raw = 3'b000;
            step(2);
            check($sformatf("bounce%0d.pending", k), pending, 3'b000);
        end
        for (int k = 0; k < 8; k++) begin
            step(1);
            check($sformatf("bounce_tail%0d.pending", k), pending, 3'b000);
        end
        check_all("bounce_end", 3'b000, 3'b000, 1'b0);

        // reset asserted mid-WAIT with pending 011
        c_f     = 2'd2;
        btn_raw = 3'b011;
        step(7);
        check_all("mid.latched", 3'b011, 3'b000, 1'b0);
        step(1);
        check_all("mid.issue_f", 3'b011, 3'b010, 1'b1);
        btn_raw = 3'b000;
        tick    = 1'b1;
        step(1);
        tick = 1'b0;
        check_all("mid.wait", 3'b011, 3'b010, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_all("mid.async_reset", 3'b000, 3'b000, 1'b0);
        step(1);
        reset = 1'b1;
        step(10);
        check_all("mid.after_release", 3'b000, 3'b000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
